// File: rtl/fifo_flex_pkg.sv
// Elaboration-time helpers shared by the fifo_flex files.
// Only constant functions live here; widths and thresholds stay module parameters.
`timescale 1ns/1ps
package fifo_flex_pkg;

    // True when v is a power of two and at least 2.
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // True when 0 <= ae < af <= depth.
    function automatic bit thresh_ok(input int depth, input int ae, input int af);
        return (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_flex.
// DEPTH x DATA_WIDTH, synchronous write, asynchronous (combinational) read.
// Contents are deliberately not reset.
`timescale 1ns/1ps
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: one word per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow and selectable standard/FWFT read mode.
`timescale 1ns/1ps
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter bit FWFT       = 1'b0,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = CNT_W'(AE_THRESH);

    if (!is_pow2(DEPTH) || DATA_WIDTH < 1) begin : g_bad_geometry
        $error("fifo_flex: DEPTH must be a power of two >= 2 and DATA_WIDTH >= 1");
    end
    if (!thresh_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
        $error("fifo_flex: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_acc;
    logic                  wr_acc;

    // Flags come only from the registered count, so a simultaneous read and
    // write (count unchanged) cannot glitch them.
    assign empty        = (cnt == '0);
    assign full         = (cnt == CNT_FULL);
    assign almost_full  = (cnt >= CNT_AF);
    assign almost_empty = (cnt <= CNT_AE);
    assign count        = cnt;

    // A read at full frees the slot the same cycle, so the write may proceed.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow <= 1'b1;
            else if (clr_err)     overflow <= 1'b0;
            if (rd_en && empty)   underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is presented directly; masked to zero while empty so the
        // unreset RAM never leaks onto dout.
        assign dout  = empty ? '0 : ram_rdata;
        assign valid = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_p1;
        logic                  vld_p1;

        // Standard read: capture the head word on an accepted read, pulse valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                if (rd_acc) dout_p1 <= ram_rdata;
            end
        end

        assign dout  = dout_p1;
        assign valid = vld_p1;
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: standard-mode instance driven by a
// queue-based reference model with a decoupled monitor, plus a small FWFT instance.
`timescale 1ns/1ps
module tb_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode DUT signals
    logic          rst, wr_en, rd_en, clr_err;
    logic [DW-1:0] din;
    logic          full, almost_full, valid, empty, almost_empty, overflow, underflow;
    logic [DW-1:0] dout;
    logic [AW:0]   count;

    // FWFT DUT signals
    logic          rst_f, wr_f, rd_f, clr_f;
    logic [DW-1:0] din_f;
    logic          full_f, af_f, valid_f, empty_f, ae_f, ovf_f, unf_f;
    logic [DW-1:0] dout_f;
    logic [AW:0]   count_f;

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .valid(valid),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fw (
        .clk(clk), .rst(rst_f), .wr_en(wr_f), .din(din_f), .full(full_f),
        .almost_full(af_f), .rd_en(rd_f), .dout(dout_f), .valid(valid_f),
        .empty(empty_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_f)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: stored words, words due on dout, sticky error state.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] last_dout = '0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; the model advances at the same edge as the DUT.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit ra, wa;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        ra = r && (m_q.size() > 0);
        wa = w && ((m_q.size() < DEPTH) || ra);
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        if (w && !wa) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && !ra) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        m_q.delete(); exp_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; last_dout = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every cycle against the model, popping expected reads.
    initial begin
        int n;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n = m_q.size();
                chk("count", int'(count), n);
                chk("empty", int'(empty), int'(n == 0));
                chk("full", int'(full), int'(n == DEPTH));
                chk("almost_full", int'(almost_full), int'(n >= DEPTH - 4));
                chk("almost_empty", int'(almost_empty), int'(n <= 4));
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("underflow", int'(underflow), int'(m_unf));
                chk("valid", int'(valid), int'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (valid) chk("rd_data", int'(dout), int'(e));
                    last_dout = e;
                end else begin
                    chk("dout_hold", int'(dout), int'(last_dout));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int af_first;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        rst_f = 1'b1; wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0; din_f = '0;

        // FWFT instance: reset state, fall-through of 0x5C, pop to empty
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_f = 1'b0;
        chk("fw_rst_valid", int'(valid_f), 0);
        chk("fw_rst_dout", int'(dout_f), 0);
        chk("fw_rst_empty", int'(empty_f), 1);
        chk("fw_rst_ae", int'(ae_f), 1);
        chk("fw_rst_full", int'(full_f), 0);
        chk("fw_rst_af", int'(af_f), 0);
        chk("fw_rst_count", int'(count_f), 0);
        chk("fw_rst_err", int'({ovf_f, unf_f}), 0);
        wr_f = 1'b1; din_f = 8'h5C;
        @(posedge clk); #1;
        chk("fw_dout", int'(dout_f), 8'h5C);
        chk("fw_valid", int'(valid_f), 1);
        chk("fw_not_empty", int'(empty_f), 0);
        @(negedge clk);
        wr_f = 1'b0; rd_f = 1'b1;
        @(posedge clk); #1;
        chk("fw_pop_empty", int'(empty_f), 1);
        chk("fw_pop_valid", int'(valid_f), 0);
        @(negedge clk);
        rd_f = 1'b0;

        // Standard instance: reset state
        do_reset();
        mon_en = 1'b1;
        chk("rst_count", int'(count), 0);
        chk("rst_flags", int'({empty, almost_empty, full, almost_full}), 4'b1100);
        chk("rst_out", int'({valid, dout}), 0);
        chk("rst_err", int'({overflow, underflow}), 0);

        // Fill 0x01..0x20
        af_first = -1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (almost_full && af_first < 0) af_first = int'(count);
        end
        chk("t1_full", int'(full), 1);
        chk("t1_count", int'(count), DEPTH);
        chk("t1_af_first", af_first, 28);

        // Simultaneous read/write at full
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("t2_count", int'(count), DEPTH);
        chk("t2_no_ovf", int'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t2_last_aa", int'(dout), 8'hAA);
        chk("t2_empty", int'(empty), 1);

        // Underflow, clear; overflow, same-cycle set beats clear, clear
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t3_unf", int'(underflow), 1);
        chk("t3_unf_valid", int'(valid), 0);
        chk("t3_unf_count", int'(count), 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("t3_unf_clr", int'(underflow), 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("t3_ovf", int'(overflow), 1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("t3_ovf_clr", int'(overflow), 0);
        cycle(1'b1, 8'h66, 1'b0, 1'b1);
        chk("t3_set_beats_clr", int'(overflow), 1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Randomised interleaved traffic, pointers wrap repeatedly
        for (int i = 0; i < 100; i++) begin
            cycle($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < 150; i++) begin
            cycle($urandom_range(0, 99) < 40, DW'($urandom), $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 5);
        end

        // Reset mid-operation with 17 words stored
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        chk("t6_count17", int'(count), 17);
        do_reset();
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_flags", int'({empty, almost_empty, full, almost_full}), 4'b1100);
        chk("t6_rst_out", int'({valid, dout}), 0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t6_new_valid", int'(valid), 1);
        chk("t6_new_data", int'(dout), 8'h77);
        chk("t6_empty", int'(empty), 1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
